// File: rtl/dist_pkg.sv
// Shared constants for the distribution tree nodes: destination masks and output indices.
package dist_pkg;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_BOTH  = 2'b11;

    localparam int LEFT  = 0;
    localparam int RIGHT = 1;

endpackage

// File: rtl/dist_fifo.sv
// Small per-child FIFO for the distribution node; head word is presented registered-only.
module dist_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    // full comes from registered state only, so a pop never frees space in the same cycle
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/distribution_demux.sv
// Registered 1-to-2 distribution node: routes each accepted word to left, right, both or neither,
// with an independent FIFO per child and a saturating count of dropped words.
module distribution_demux
    import dist_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     i_data,
    input  logic [1:0]       i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [2*W-1:0]   o_data,
    output logic [1:0]       o_valid,
    input  logic [1:0]       i_ready,
    output logic [CNT_W-1:0] o_drop_cnt
);

    logic [1:0]       full, empty, push, pop;
    logic             fire;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Multicast waits for space in both FIFOs; ready never looks at i_ready.
    assign o_ready    = (!i_sel[LEFT]  || !full[LEFT]) &&
                        (!i_sel[RIGHT] || !full[RIGHT]);
    assign fire       = i_valid && o_ready;
    assign push       = {2{fire}} & i_sel;
    assign o_valid    = ~empty;
    assign pop        = o_valid & i_ready;
    assign o_drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (fire && (i_sel == SEL_NONE) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_out
        dist_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .din   (i_data),
            .pop   (pop[k]),
            .dout  (o_data[k*W +: W]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

endmodule

// File: tb/tb_distribution_demux.sv
// Bench for distribution_demux: queue-based reference model checked every cycle, plus directed scenarios.
module tb_distribution_demux;

    localparam int W     = 16;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int DMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     i_data;
    logic [1:0]       i_sel;
    logic             i_valid;
    logic             o_ready;
    logic [2*W-1:0]   o_data;
    logic [1:0]       o_valid;
    logic [1:0]       i_ready;
    logic [CNT_W-1:0] o_drop_cnt;

    distribution_demux #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_sel      (i_sel),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q_l[$];
    logic [W-1:0] q_r[$];
    int           drops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (!i_sel[0] || (q_l.size() < DEPTH)) && (!i_sel[1] || (q_r.size() < DEPTH));
    endfunction

    // Reference model: state as queues, updated from the rules at each rising edge.
    logic m_fire, m_pl, m_pr;
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_fire = i_valid && m_ready();
            m_pl   = (q_l.size() != 0) && i_ready[0];
            m_pr   = (q_r.size() != 0) && i_ready[1];
            if (m_pl) void'(q_l.pop_front());
            if (m_pr) void'(q_r.pop_front());
            if (m_fire) begin
                if (i_sel[0]) q_l.push_back(i_data);
                if (i_sel[1]) q_r.push_back(i_data);
                if (i_sel == 2'b00 && drops < DMAX) drops++;
            end
        end
    end

    always @(negedge rst_n) begin
        q_l.delete();
        q_r.delete();
        drops = 0;
    end

    logic [W-1:0] exp_l, exp_r;
    always @(negedge clk) begin
        exp_l = (q_l.size() != 0) ? q_l[0] : '0;
        exp_r = (q_r.size() != 0) ? q_r[0] : '0;
        check("o_ready",  64'(o_ready), 64'(m_ready()));
        check("o_valid",  64'(o_valid), 64'({q_r.size() != 0, q_l.size() != 0}));
        check("o_data_l", 64'(o_data[W-1:0]), 64'(exp_l));
        check("o_data_r", 64'(o_data[2*W-1:W]), 64'(exp_r));
        check("drop_cnt", 64'(o_drop_cnt), 64'(drops));
    end

    task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d, input logic [1:0] rdy);
        i_valid = v;
        i_sel   = sel;
        i_data  = d;
        i_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, '0, 2'b00);
        #1;
        check("reset_valid", 64'(o_valid), 64'(0));
        check("reset_data",  64'(o_data), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Unicast left
        drive(1'b1, 2'b01, 16'h1234, 2'b11);
        #1 check("uni_ready", 64'(o_ready), 64'(1));
        tick();
        i_valid = 1'b0;
        #1;
        check("uni_valid", 64'(o_valid), 64'(2'b01));
        check("uni_data",  64'(o_data[15:0]), 64'(16'h1234));
        tick(); tick();

        // Multicast with stalled right child
        drive(1'b1, 2'b11, 16'h00A0, 2'b01);
        tick();
        i_data = 16'h00A1;
        tick();
        i_data = 16'h00A2;
        #1 check("mc_blocked", 64'(o_ready), 64'(0));
        check("mc_left_a1", 64'(o_data[15:0]), 64'(16'h00A1));
        tick(); tick();
        check("mc_right_head", 64'(o_data[31:16]), 64'(16'h00A0));
        i_ready = 2'b11;
        begin
            int budget = 10;
            while (!o_ready && budget > 0) begin
                tick();
                budget--;
            end
            check("mc_unblock", 64'(budget > 0), 64'(1));
        end
        check("mc_right_a1", 64'(o_data[31:16]), 64'(16'h00A1));
        tick();
        i_valid = 1'b0;
        repeat (4) tick();

        // Independence: right full, left still accepts
        drive(1'b1, 2'b10, 16'h0011, 2'b00);
        tick();
        i_data = 16'h0022;
        tick();
        drive(1'b1, 2'b01, 16'h0055, 2'b00);
        #1 check("ind_ready", 64'(o_ready), 64'(1));
        tick();
        i_valid = 1'b0;
        i_ready = 2'b01;
        #1 check("ind_left", 64'(o_data[15:0]), 64'(16'h0055));
        check("ind_right_blocked", 64'(o_data[31:16]), 64'(16'h0011));
        i_ready = 2'b11;
        repeat (4) tick();

        // Drop saturation
        drive(1'b1, 2'b00, 16'hBEEF, 2'b11);
        repeat (20) tick();
        i_valid = 1'b0;
        #1 check("drop_sat", 64'(o_drop_cnt), 64'(15));
        check("drop_novalid", 64'(o_valid), 64'(0));
        tick();

        // Simultaneous push/pop on the left, 8 back-to-back words
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'b01, W'(k), 2'b01);
            tick();
            check("pp_head", 64'(o_data[15:0]), 64'(k));
        end
        i_valid = 1'b0;
        tick(); tick();

        // Mid-stream reset
        drive(1'b1, 2'b11, 16'h0077, 2'b00);
        tick();
        i_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_data",  64'(o_data), 64'(0));
        check("rst_drop",  64'(o_drop_cnt), 64'(0));
        #1 rst_n = 1'b1;
        tick();
        drive(1'b1, 2'b01, 16'h0099, 2'b11);
        tick();
        i_valid = 1'b0;
        #1 check("post_rst", 64'(o_data[15:0]), 64'(16'h0099));
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 2'($urandom));
            tick();
        end
        i_valid = 1'b0;
        i_ready = 2'b11;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
